// File: rtl/uart_tx_fifo_pkg.sv
// ============================================================================
//  Module  : uart_tx_fifo_pkg
//  Purpose : Shared widths, FIFO depth default and launch FSM encoding for the
//            UART transmit buffer.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_tx_fifo_pkg;

   localparam int c_data_width = 8;
   localparam int c_depth      = 16;

   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      WAIT_DONE = 1'b1
   } tx_state_t;

   // Occupancy after one edge; a same-edge push and pop cancel out.
   function automatic int level_next(input int level, input logic push, input logic pop);
      return level + (push ? 1 : 0) - (pop ? 1 : 0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_sync_fifo.sv
// ============================================================================
//  Module  : uart_tx_fifo_sync_fifo
//  Purpose : Synchronous FIFO with registered count/full/empty/overflow and a
//            combinational read port at the read pointer.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo_sync_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = c_data_width,
   parameter int DEPTH      = c_depth,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_W:0]       count,
   output logic                  overflow
);

   localparam logic [ADDR_W:0] c_full_level = (ADDR_W+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0]     r_wr_ptr;
   logic [ADDR_W-1:0]     r_rd_ptr;
   logic [ADDR_W:0]       r_count;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_overflow;

   logic                  w_push;
   logic                  w_pop;
   logic [ADDR_W:0]       w_count_next;

   // A pop on the same edge frees the slot, so a write into a full FIFO is
   // still accepted when the reader drains one entry at that edge.
   assign w_pop        = rd_en && !r_empty;
   assign w_push       = wr_en && (!r_full || w_pop);
   assign w_count_next = (ADDR_W+1)'(level_next(int'(r_count), w_push, w_pop));

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
         r_count    <= w_count_next;
         r_full     <= (w_count_next == c_full_level);
         r_empty    <= (w_count_next == '0);
         r_overflow <= wr_en && !w_push;
      end
   end

   assign rd_data  = r_mem[r_rd_ptr];
   assign full     = r_full;
   assign empty    = r_empty;
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module  : uart_tx_fifo
//  Purpose : Byte buffer feeding a UART transmitter; launches one byte per
//            frame and waits for the frame-done pulse before the next.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = c_data_width,
   parameter int DEPTH      = c_depth,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_W:0]       count,
   output logic                  overflow,
   output logic                  tx_start,
   output logic [DATA_WIDTH-1:0] tx_in,
   input  logic                  tx_dv
);

   tx_state_t             r_state;
   tx_state_t             w_state_next;
   logic                  r_tx_start;
   logic [DATA_WIDTH-1:0] r_tx_in;
   logic                  w_tx_start_next;
   logic [DATA_WIDTH-1:0] w_tx_in_next;
   logic                  w_pop;
   logic [DATA_WIDTH-1:0] w_rd_data;

   uart_tx_fifo_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (w_pop),
      .rd_data  (w_rd_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_tx_start <= 1'b0;
         r_tx_in    <= '0;
      end else begin
         r_state    <= w_state_next;
         r_tx_start <= w_tx_start_next;
         r_tx_in    <= w_tx_in_next;
      end
   end

   // tx_dv is only meaningful while a frame is outstanding; IDLE ignores it.
   always_comb begin
      w_state_next    = r_state;
      w_pop           = 1'b0;
      w_tx_start_next = 1'b0;
      w_tx_in_next    = r_tx_in;
      case (r_state)
         IDLE: begin
            if (!empty) begin
               w_pop           = 1'b1;
               w_tx_start_next = 1'b1;
               w_tx_in_next    = w_rd_data;
               w_state_next    = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (tx_dv) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign tx_start = r_tx_start;
   assign tx_in    = r_tx_in;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
//  Module  : tb_uart_tx_fifo
//  Purpose : Self-checking bench for uart_tx_fifo against a queue-based model
//            with an emulated transmitter returning tx_dv after a random delay.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          tx_start;
   logic [DW-1:0] tx_in;
   logic          tx_dv;

   uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .tx_start (tx_start),
      .tx_in    (tx_in),
      .tx_dv    (tx_dv)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: bytes waiting, a frame-in-flight flag, last launch
   logic [DW-1:0] mq[$];
   bit            m_busy;
   bit            m_start;
   bit            m_ovf;
   logic [DW-1:0] m_in;
   logic [DW-1:0] launched[$];
   bit            auto_tx;
   int            cd;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_busy  = 0;
      m_start = 0;
      m_ovf   = 0;
      m_in    = '0;
      cd      = 0;
   endtask

   task automatic model_edge(input logic wr, input logic [DW-1:0] d, input logic dv);
      bit pop;
      bit push;
      pop   = !m_busy && (mq.size() > 0);
      push  = wr && ((mq.size() < DEPTH) || pop);
      m_ovf = wr && !push;
      m_start = pop;
      if (pop) begin
         m_in   = mq.pop_front();
         m_busy = 1;
      end else if (m_busy && dv) begin
         m_busy = 0;
      end
      if (push) mq.push_back(d);
   endtask

   task automatic check_model();
      check_val("count",    32'(count),    32'(mq.size()));
      check_val("full",     32'(full),     32'(mq.size() == DEPTH));
      check_val("empty",    32'(empty),    32'(mq.size() == 0));
      check_val("overflow", 32'(overflow), 32'(m_ovf));
      check_val("tx_start", 32'(tx_start), 32'(m_start));
      check_val("tx_in",    32'(tx_in),    32'(m_in));
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_full"},     32'(full),     0);
      check_val({tag, "_empty"},    32'(empty),    1);
      check_val({tag, "_count"},    32'(count),    0);
      check_val({tag, "_overflow"}, 32'(overflow), 0);
      check_val({tag, "_tx_start"}, 32'(tx_start), 0);
      check_val({tag, "_tx_in"},    32'(tx_in),    0);
   endtask

   // one clock: drive inputs, take the edge, update model, compare
   task automatic step(input logic wr, input logic [DW-1:0] d, input logic force_dv);
      logic dv;
      if (auto_tx && m_busy && cd == 0) cd = $urandom_range(1, 6);
      dv = force_dv;
      if (cd == 1) dv = 1'b1;
      if (cd > 0) cd--;
      wr_en   = wr;
      wr_data = d;
      tx_dv   = dv;
      @(posedge clk);
      model_edge(wr, d, dv);
      #1;
      check_model();
      if (tx_start === 1'b1) launched.push_back(tx_in);
      wr_en = 1'b0;
      tx_dv = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard   = 0;
      auto_tx = 1;
      while ((mq.size() > 0 || m_busy) && guard < 400) begin
         step(1'b0, '0, 1'b0);
         guard++;
      end
      check_val("drain_bound", 32'(guard < 400), 1);
   endtask

   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      #1 check_reset_vals(tag);
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_reset_vals({tag, "_hold"});
      #4 rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b1;
      wr_en   = 1'b0;
      wr_data = '0;
      tx_dv   = 1'b0;
      auto_tx = 0;
      model_reset();

      // power-on reset asserted mid-cycle
      #5 rst_n = 1'b0;
      #1 check_reset_vals("por");
      model_reset();
      repeat (2) @(posedge clk);
      #5 rst_n = 1'b1;
      repeat (4) step(1'b0, '0, 1'b0);

      // single byte
      launched.delete();
      step(1'b1, 8'h55, 1'b0);
      check_val("single_count", 32'(count), 1);
      step(1'b0, '0, 1'b0);
      check_val("single_start", 32'(tx_start), 1);
      check_val("single_tx_in", 32'(tx_in), 32'h55);
      drain();
      check_val("single_n", 32'(launched.size()), 1);
      check_val("single_cnt0", 32'(count), 0);

      // three-byte burst
      auto_tx = 0;
      launched.delete();
      step(1'b1, 8'h55, 1'b0);
      step(1'b1, 8'hF0, 1'b0);
      step(1'b1, 8'h3C, 1'b0);
      check_val("burst_peak", 32'(count), 2);
      drain();
      check_val("burst_n", 32'(launched.size()), 3);
      if (launched.size() == 3) begin
         check_val("burst_b0", 32'(launched[0]), 32'h55);
         check_val("burst_b1", 32'(launched[1]), 32'hF0);
         check_val("burst_b2", 32'(launched[2]), 32'h3C);
      end

      // overflow: 18 writes with the first frame held open
      auto_tx = 0;
      cd      = 0;
      launched.delete();
      for (int i = 0; i < 18; i++) step(1'b1, DW'(i), 1'b0);
      check_val("ovf_full",  32'(full), 1);
      check_val("ovf_pulse", 32'(overflow), 1);
      check_val("ovf_count", 32'(count), 16);

      // full + pop aligned with a write
      step(1'b0, '0, 1'b1);
      check_val("fp_ovf_clr", 32'(overflow), 0);
      step(1'b1, 8'hA5, 1'b0);
      check_val("fp_count", 32'(count), 16);
      check_val("fp_ovf",   32'(overflow), 0);
      check_val("fp_start", 32'(tx_start), 1);
      drain();
      check_val("fp_n", 32'(launched.size()), 18);
      if (launched.size() == 18) begin
         check_val("fp_first", 32'(launched[0]),  32'h00);
         check_val("fp_mid",   32'(launched[16]), 32'h10);
         check_val("fp_last",  32'(launched[17]), 32'hA5);
      end

      // reset during the second frame with five bytes queued
      auto_tx = 0;
      cd      = 0;
      for (int i = 0; i < 7; i++) step(1'b1, DW'(8'h80 + i), 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      check_val("mid_count", 32'(count), 5);
      check_val("mid_start", 32'(tx_start), 1);
      async_reset("midrst");
      repeat (6) step(1'b0, '0, 1'b0);

      // randomized traffic with bursty and sparse phases
      auto_tx = 1;
      for (int blk = 0; blk < 20; blk++) begin
         int pct;
         pct = (blk % 2 == 0) ? 85 : 15;
         for (int i = 0; i < 100; i++) begin
            step(($urandom % 100) < pct, DW'($urandom), ($urandom % 100) < 3);
         end
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
